// File: rtl/debug_dump_unit.sv
// debug_dump_unit: UART-driven run/halt/step controller that snapshots PC, instruction and register file and streams them as a framed byte dump.
// Optional DEBUG_CYCLE_COUNT_EN appends a saturating 32-bit enabled-cycle counter to every frame and adds the 'z' clear command.
module debug_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 32,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic [7:0]                   rxData,
  input  logic                         rxValid,
  output logic [7:0]                   txData,
  output logic                         txValid,
  input  logic                         txReady,
  input  logic [NUM_REGS*DATA_W-1:0]   regFlat,
  input  logic [DATA_W-1:0]            pc,
  input  logic [31:0]                  instr,
  output logic                         enable,
  output logic                         halted,
  output logic                         busy,
  output logic [7:0]                   cmdEcho
);
  localparam int DB = DATA_W / 8;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int CB = 4;
`else
  localparam int CB = 0;
`endif
  localparam int NB = 1 + DB + 4 + NUM_REGS * DB + CB;
  localparam int FW = NB * 8;
  localparam int IW = $clog2(NB + 1);
  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_CAP, S_SEND} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [FW-1:0] snap, frame;
  logic cmd_ok, known, acc, last;
  assign cmd_ok = rxValid && (state == S_HALT || state == S_RUN);
  assign txValid = state == S_SEND;
  assign txData = txValid ? snap[FW-1 -: 8] : 8'h00;
  assign acc = txValid && txReady;
  assign last = idx == IW'(NB - 1);
  assign enable = state == S_RUN || state == S_STEP;
  assign halted = state == S_HALT;
  assign busy = state == S_CAP || state == S_SEND;
`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;
  logic clr;
  assign clr = cmd_ok && state == S_HALT && rxData == 8'h7A;
  assign known = rxData inside {8'h63, 8'h68, 8'h73, 8'h64} || clr;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cyc_cnt <= '0;
    else if (clr) cyc_cnt <= '0;
    else if (enable && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
`else
  assign known = rxData inside {8'h63, 8'h68, 8'h73, 8'h64};
`endif
  always_comb begin
    frame = '0;
    frame[FW-1 -: 8] = HDR_BYTE;
    frame[FW-9 -: DATA_W] = pc;
    frame[FW-9-DATA_W -: 32] = instr;
    for (int i = 0; i < NUM_REGS; i++)
      frame[CB*8 + (NUM_REGS-1-i)*DATA_W +: DATA_W] = regFlat[i*DATA_W +: DATA_W];
`ifdef DEBUG_CYCLE_COUNT_EN
    frame[31:0] = cyc_cnt;
`endif
  end
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      S_HALT, S_RUN:
        if (cmd_ok)
          state_nx = rxData == 8'h63 ? S_RUN :
                     rxData == 8'h68 ? S_HALT :
                     rxData == 8'h73 ? S_STEP :
                     rxData == 8'h64 ? S_CAP : state;
      S_STEP: state_nx = S_CAP;
      S_CAP: begin
        state_nx = S_SEND;
        idx_nx = '0;
      end
      S_SEND:
        if (acc) begin
          idx_nx = idx + 1'b1;
          state_nx = last ? S_HALT : S_SEND;
        end
      default: state_nx = S_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= S_HALT;
      idx <= '0;
      cmdEcho <= 8'h00;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      cmdEcho <= cmd_ok && known ? rxData : cmdEcho;
    end
  // The snapshot is a shift register: the head byte is always the one on the wire.
  always_ff @(posedge clk)
    if (state == S_CAP) snap <= frame;
    else if (acc) snap <= snap << 8;
endmodule

// File: tb/tb_debug_dump_unit.sv
// tb_debug_dump_unit: directed, table-driven bench for debug_dump_unit (default parameters).
module tb_debug_dump_unit;
  localparam int NR = 32;
  localparam int DW = 32;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int NB = 141;
  logic [31:0] exp_cnt;
`else
  localparam int NB = 137;
`endif
  logic clk = 1'b0, resetN = 1'b0;
  logic [7:0] rxData = 8'h00, txData, cmdEcho;
  logic rxValid = 1'b0, txValid, txReady = 1'b0, enable, halted, busy;
  logic [NR*DW-1:0] regFlat = '0;
  logic [DW-1:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] rv [NR];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int pass_n = 0, total_n = 0, en_seen = 0;
  typedef struct { logic [7:0] cmd; logic en; logic hl; logic [7:0] echo; } vec_t;
  vec_t vt[8];

  debug_dump_unit dut (
    .clk(clk), .resetN(resetN), .rxData(rxData), .rxValid(rxValid),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .regFlat(regFlat), .pc(pc), .instr(instr),
    .enable(enable), .halted(halted), .busy(busy), .cmdEcho(cmdEcho)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_n++;
    if (act === expv) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic set_regs(input logic [31:0] mul, input logic [31:0] add);
    for (int i = 0; i < NR; i++) begin
      rv[i] = mul * i + add;
      regFlat[i*DW +: DW] = rv[i];
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int b = 3; b >= 0; b--) exp_q.push_back(pc[b*8 +: 8]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(instr[b*8 +: 8]);
    for (int i = 0; i < NR; i++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(rv[i][b*8 +: 8]);
`ifdef DEBUG_CYCLE_COUNT_EN
    for (int b = 3; b >= 0; b--) exp_q.push_back(exp_cnt[b*8 +: 8]);
`endif
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rxData = b;
    rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic get_frame(input bit slow, input bit inject, input bit scramble);
    int cyc = 0;
    bit stalled = 0;
    logic [7:0] held = 8'h00;
    got.delete();
    en_seen = 0;
    while ((!halted || busy) && cyc < 3000) begin
      if (stalled) chk("stall_hold", {23'd0, txValid, txData}, {23'd0, 1'b1, held});
      txReady = slow ? (cyc % 3 == 2) : 1'b1;
      rxValid = inject && cyc == 10;
      rxData = 8'h63;
      if (scramble && cyc == 20) begin
        pc = 32'hDEADBEEF;
        instr = 32'h12345678;
        set_regs(32'h11111111, 32'h00000007);
      end
      stalled = txValid && !txReady;
      held = txData;
      if (enable) en_seen++;
      if (txValid && txReady) got.push_back(txData);
      @(posedge clk); #1;
      cyc++;
    end
    rxValid = 1'b0;
    txReady = 1'b0;
    chk("frame_done", {31'd0, cyc < 3000}, 32'd1);
  endtask

  task automatic check_frame(input string name);
    chk({name, "_len"}, got.size(), NB);
    for (int i = 0; i < NB && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    set_regs(32'h0, 32'h0);
    vt[0] = '{8'h63, 1'b1, 1'b0, 8'h63};
    vt[1] = '{8'h00, 1'b1, 1'b0, 8'h63};
    vt[2] = '{8'h68, 1'b0, 1'b1, 8'h68};
    vt[3] = '{8'h00, 1'b0, 1'b1, 8'h68};
`ifdef DEBUG_CYCLE_COUNT_EN
    vt[4] = '{8'h7A, 1'b0, 1'b1, 8'h7A};
`else
    vt[4] = '{8'h7A, 1'b0, 1'b1, 8'h68};
`endif
    vt[5] = '{8'h63, 1'b1, 1'b0, 8'h63};
    vt[6] = '{8'h63, 1'b1, 1'b0, 8'h63};
    vt[7] = '{8'h68, 1'b0, 1'b1, 8'h68};
    #1;
    chk("rst_txValid", {31'd0, txValid}, 0);
    chk("rst_txData", {24'd0, txData}, 0);
    chk("rst_enable", {31'd0, enable}, 0);
    chk("rst_halted", {31'd0, halted}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cmdEcho", {24'd0, cmdEcho}, 0);
    #20 resetN = 1'b1;
    @(posedge clk); #1;
    chk("idle_enable", {31'd0, enable}, 0);
    for (int i = 0; i < 8; i++) begin
      send_cmd(vt[i].cmd);
      chk($sformatf("vec%0d_enable", i), {31'd0, enable}, {31'd0, vt[i].en});
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vt[i].hl});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 0);
      chk($sformatf("vec%0d_cmdEcho", i), {24'd0, cmdEcho}, {24'd0, vt[i].echo});
    end
    // single step: one enabled cycle, capture, then auto-dump
`ifdef DEBUG_CYCLE_COUNT_EN
    send_cmd(8'h7A);
    exp_cnt = 1;
`endif
    pc = 32'h00000040;
    instr = 32'h8C220004;
    set_regs(32'h01010101, 32'h0);
    build_exp();
    send_cmd(8'h73);
    chk("step_en_t1", {31'd0, enable}, 1);
    chk("step_halted_t1", {31'd0, halted}, 0);
    @(posedge clk); #1;
    chk("step_en_t2", {31'd0, enable}, 0);
    chk("step_busy_t2", {31'd0, busy}, 1);
    chk("step_txValid_t2", {31'd0, txValid}, 0);
    @(posedge clk); #1;
    chk("step_txValid_t3", {31'd0, txValid}, 1);
    chk("step_txData_t3", {24'd0, txData}, 32'hA5);
    get_frame(0, 0, 0);
    check_frame("step");
    chk("step_no_enable", en_seen, 0);
    chk("step_halted_end", {31'd0, halted}, 1);
    chk("step_txValid_end", {31'd0, txValid}, 0);
    // backpressure, ignored 'c' during SEND, inputs changed mid-frame
`ifdef DEBUG_CYCLE_COUNT_EN
    send_cmd(8'h7A);
    exp_cnt = 0;
`endif
    build_exp();
    send_cmd(8'h64);
    get_frame(1, 1, 1);
    check_frame("slow");
    chk("slow_cmdEcho", {24'd0, cmdEcho}, 32'h64);
    chk("slow_halted", {31'd0, halted}, 1);
    send_cmd(8'h00);
    chk("null_halted", {31'd0, halted}, 1);
    chk("null_cmdEcho", {24'd0, cmdEcho}, 32'h64);
    build_exp();
    send_cmd(8'h64);
    get_frame(0, 0, 0);
    check_frame("fresh");
    // reset mid-frame
    build_exp();
    send_cmd(8'h64);
    txReady = 1'b1;
    begin
      int n = 0, guard = 0;
      while (n < 50 && guard < 500) begin
        if (txValid) n++;
        guard++;
        @(posedge clk); #1;
      end
      chk("abort_reached50", n, 50);
    end
    resetN = 1'b0;
    #1;
    chk("abort_txValid", {31'd0, txValid}, 0);
    chk("abort_txData", {24'd0, txData}, 0);
    chk("abort_enable", {31'd0, enable}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_halted", {31'd0, halted}, 1);
    chk("abort_cmdEcho", {24'd0, cmdEcho}, 0);
    #2 resetN = 1'b1;
    txReady = 1'b0;
    @(posedge clk); #1;
`ifdef DEBUG_CYCLE_COUNT_EN
    exp_cnt = 0;
`endif
    build_exp();
    send_cmd(8'h64);
    get_frame(0, 0, 0);
    check_frame("after_reset");
`ifdef DEBUG_CYCLE_COUNT_EN
    send_cmd(8'h63);
    repeat (99) @(posedge clk);
    #1;
    exp_cnt = 100;
    build_exp();
    send_cmd(8'h64);
    get_frame(0, 0, 0);
    check_frame("count100");
    send_cmd(8'h7A);
    chk("z_cmdEcho", {24'd0, cmdEcho}, 32'h7A);
    exp_cnt = 0;
    build_exp();
    send_cmd(8'h64);
    get_frame(0, 0, 0);
    check_frame("count_clr");
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
